// File: rtl/pulse_event_arbiter.sv
// Merges two single-cycle pulse sources onto one valid/ready event channel.
// Per-source saturating backlog counters feed a round-robin offer FSM.
module pulse_event_arbiter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seq_a,
  input  logic             seq_b,
  input  logic             enable,
  input  logic             evt_ready,
  input  logic             clr_ovf,
  output logic             evt_valid,
  output logic             evt_id,
  output logic [CNT_W-1:0] pend_a,
  output logic [CNT_W-1:0] pend_b,
  output logic             ovf_a,
  output logic             ovf_b
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             last_id;
  logic             last_id_nxt;
  logic             evt_valid_nxt;
  logic             evt_id_nxt;
  logic             hs;
  logic             dec_a;
  logic             dec_b;
  logic             drop_a;
  logic             drop_b;
  logic             last_eff;
  logic             sel;
  logic [CNT_W-1:0] pend_a_nxt;
  logic [CNT_W-1:0] pend_b_nxt;

  // Saturating up/down step; a simultaneous inc and dec cancel even at max.
  function automatic logic [CNT_W-1:0] cnt_step(input logic [CNT_W-1:0] cnt,
                                                input logic             inc,
                                                input logic             dec);
    logic [CNT_W-1:0] res;
    res = cnt;
    if (inc && !dec && (cnt != {CNT_W{1'b1}})) begin
      res = cnt + CNT_W'(1);
    end else if (dec && !inc && (cnt != '0)) begin
      res = cnt - CNT_W'(1);
    end
    return res;
  endfunction

  function automatic logic cnt_drop(input logic [CNT_W-1:0] cnt,
                                    input logic             inc,
                                    input logic             dec);
    return inc && !dec && (cnt == {CNT_W{1'b1}});
  endfunction

  assign hs     = evt_valid & evt_ready;
  assign dec_a  = hs & (evt_id == 1'b0);
  assign dec_b  = hs & (evt_id == 1'b1);

  assign pend_a_nxt = cnt_step(pend_a, seq_a, dec_a);
  assign pend_b_nxt = cnt_step(pend_b, seq_b, dec_b);
  assign drop_a     = cnt_drop(pend_a, seq_a, dec_a);
  assign drop_b     = cnt_drop(pend_b, seq_b, dec_b);

  // Arbitration looks at post-handshake counts and the post-handshake last_id,
  // so back-to-back grants alternate correctly on ties.
  always_comb begin
    last_eff = hs ? evt_id : last_id;
    sel      = 1'b0;
    if ((pend_a_nxt != '0) && (pend_b_nxt != '0)) begin
      sel = ~last_eff;
    end else if (pend_b_nxt != '0) begin
      sel = 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    evt_valid_nxt = evt_valid;
    evt_id_nxt    = evt_id;
    last_id_nxt   = last_id;
    unique case (state)
      IDLE: begin
        evt_valid_nxt = 1'b0;
        if (enable && ((pend_a | pend_b) != '0)) begin
          state_nxt     = OFFER;
          evt_valid_nxt = 1'b1;
          evt_id_nxt    = sel;
        end
      end
      OFFER: begin
        // Without a handshake the offer is held unchanged, regardless of enable.
        if (hs) begin
          last_id_nxt = evt_id;
          if (enable && ((pend_a_nxt | pend_b_nxt) != '0)) begin
            evt_valid_nxt = 1'b1;
            evt_id_nxt    = sel;
          end else begin
            state_nxt     = IDLE;
            evt_valid_nxt = 1'b0;
          end
        end
      end
      default: begin
        state_nxt     = IDLE;
        evt_valid_nxt = 1'b0;
      end
    endcase
  end

  // Register stage: FSM, offer outputs, counters and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_id    <= 1'b0;
      last_id   <= 1'b1;
      pend_a    <= '0;
      pend_b    <= '0;
      ovf_a     <= 1'b0;
      ovf_b     <= 1'b0;
    end else begin
      state     <= state_nxt;
      evt_valid <= evt_valid_nxt;
      evt_id    <= evt_id_nxt;
      last_id   <= last_id_nxt;
      pend_a    <= pend_a_nxt;
      pend_b    <= pend_b_nxt;
      ovf_a     <= drop_a | (ovf_a & ~clr_ovf);
      ovf_b     <= drop_b | (ovf_b & ~clr_ovf);
    end
  end

endmodule

// File: tb/tb_pulse_event_arbiter.sv
// Directed bench for pulse_event_arbiter with CNT_W=2 so saturation is cheap to reach.
module tb_pulse_event_arbiter;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             seq_a;
  logic             seq_b;
  logic             enable;
  logic             evt_ready;
  logic             clr_ovf;
  logic             evt_valid;
  logic             evt_id;
  logic [CNT_W-1:0] pend_a;
  logic [CNT_W-1:0] pend_b;
  logic             ovf_a;
  logic             ovf_b;

  int total;
  int bad;
  int n_evt;

  pulse_event_arbiter #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seq_a     (seq_a),
    .seq_b     (seq_b),
    .enable    (enable),
    .evt_ready (evt_ready),
    .clr_ovf   (clr_ovf),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .pend_a    (pend_a),
    .pend_b    (pend_b),
    .ovf_a     (ovf_a),
    .ovf_b     (ovf_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n     = 1'b0;
    seq_a     = 1'b0;
    seq_b     = 1'b0;
    clr_ovf   = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    enable    = 1'b1;
    evt_ready = 1'b1;
    reset_dut();
    chk("rst_valid", evt_valid, 0);
    chk("rst_id", evt_id, 0);
    chk("rst_pend_a", pend_a, 0);
    chk("rst_pend_b", pend_b, 0);
    chk("rst_ovf", {ovf_a, ovf_b}, 0);

    // single A pulse
    seq_a = 1'b1; step(); seq_a = 1'b0;
    chk("t1_pend_a", pend_a, 1);
    chk("t1_valid_early", evt_valid, 0);
    step();
    chk("t1_valid", evt_valid, 1);
    chk("t1_id", evt_id, 0);
    step();
    chk("t1_pend_a_done", pend_a, 0);
    chk("t1_idle", evt_valid, 0);

    // simultaneous pairs alternate A then B
    reset_dut();
    for (int p = 0; p < 2; p++) begin
      seq_a = 1'b1; seq_b = 1'b1; step(); seq_a = 1'b0; seq_b = 1'b0;
      chk("t2_pend_ab", {pend_a, pend_b}, 5);
      step();
      chk("t2_first_valid", evt_valid, 1);
      chk("t2_first_id", evt_id, 0);
      step();
      chk("t2_second_valid", evt_valid, 1);
      chk("t2_second_id", evt_id, 1);
      chk("t2_pend_b", pend_b, 1);
      step();
      chk("t2_idle", evt_valid, 0);
      chk("t2_pend_empty", {pend_a, pend_b}, 0);
    end

    // saturation, overflow, clear, drain
    reset_dut();
    evt_ready = 1'b0;
    seq_a = 1'b1;
    for (int i = 0; i < 5; i++) step();
    seq_a = 1'b0;
    chk("t3_pend_sat", pend_a, 3);
    chk("t3_ovf_a", ovf_a, 1);
    chk("t3_ovf_b", ovf_b, 0);
    clr_ovf = 1'b1; step(); clr_ovf = 1'b0;
    chk("t3_ovf_clr", ovf_a, 0);
    evt_ready = 1'b1;
    n_evt = 0;
    for (int i = 0; i < 6; i++) begin
      if (evt_valid) begin
        n_evt++;
        chk("t3_evt_id", evt_id, 0);
      end
      step();
    end
    chk("t3_evt_count", n_evt, 3);
    chk("t3_pend_drained", pend_a, 0);

    // stalled offer holds through enable=0 and new B pulses
    reset_dut();
    evt_ready = 1'b0;
    seq_a = 1'b1; step(); seq_a = 1'b0;
    step();
    chk("t4_offer_id", evt_id, 0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seq_b = (i < 2);
      step();
      chk("t4_hold_valid", evt_valid, 1);
      chk("t4_hold_id", evt_id, 0);
    end
    seq_b = 1'b0;
    chk("t4_pend_b", pend_b, 2);
    evt_ready = 1'b1;
    step();
    chk("t4_idle_disabled", evt_valid, 0);
    chk("t4_pend_a", pend_a, 0);
    chk("t4_pend_b_kept", pend_b, 2);
    enable = 1'b1;
    step();
    chk("t4_b_valid", evt_valid, 1);
    chk("t4_b_id", evt_id, 1);
    step();
    step();
    chk("t4_b_drained", {evt_valid, pend_b}, 0);

    // inc and handshake in the same cycle at max
    reset_dut();
    evt_ready = 1'b0;
    seq_a = 1'b1;
    for (int i = 0; i < 3; i++) step();
    seq_a = 1'b0;
    chk("t5_pend_max", pend_a, 3);
    chk("t5_offer", {evt_valid, evt_id}, 2);
    seq_a = 1'b1; evt_ready = 1'b1;
    step();
    seq_a = 1'b0; evt_ready = 1'b0;
    chk("t5_pend_hold", pend_a, 3);
    chk("t5_no_ovf", ovf_a, 0);
    chk("t5_still_valid", evt_valid, 1);

    // asynchronous reset mid-offer
    reset_dut();
    evt_ready = 1'b0;
    seq_a = 1'b1; seq_b = 1'b1; step(); seq_b = 1'b0;
    for (int i = 0; i < 3; i++) step();
    seq_a = 1'b0;
    chk("t6_pre_ovf", ovf_a, 1);
    chk("t6_pre_valid", evt_valid, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_valid", evt_valid, 0);
    chk("t6_async_pend", {pend_a, pend_b}, 0);
    chk("t6_async_ovf", {ovf_a, ovf_b}, 0);
    step();
    rst_n = 1'b1;
    evt_ready = 1'b1;
    seq_a = 1'b1; seq_b = 1'b1; step(); seq_a = 1'b0; seq_b = 1'b0;
    step();
    chk("t6_tie_valid", evt_valid, 1);
    chk("t6_tie_id", evt_id, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
